// File: rtl/store_unit.sv
// store_unit: MEM-stage store path; aligns address, builds byte enables and lane data,
// and runs a req/ready write handshake with timeout, stalling the pipeline meanwhile.
module store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [1:0]  store_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byteen,
    output logic        st_stall,
    output logic        st_misalign,
    output logic        st_buserr
);
    localparam int CW = $clog2(TIMEOUT);
    typedef enum logic {IDLE, REQ} state_t;
    state_t        state, state_n;
    logic [CW-1:0] count, count_n;
    logic          sw, sh, aligned, store, go, last;
    logic          req_n, misalign_n, buserr_n;
    logic [31:0]   addr_n, wdata_n;
    logic [3:0]    byteen_n;
    assign sw      = store_type == 2'b01;
    assign sh      = store_type == 2'b10;
    assign aligned = sw ? addr[1:0] == 2'b00 : sh ? !addr[0] : 1'b1;
    assign store   = state == IDLE && st_valid && store_type != 2'b00;
    assign go      = store && aligned;
    assign last    = count == CW'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state       <= IDLE;
            count       <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_byteen  <= '0;
            st_misalign <= 1'b0;
            st_buserr   <= 1'b0;
        end else begin
            state       <= state_n;
            count       <= count_n;
            mem_req     <= req_n;
            mem_addr    <= addr_n;
            mem_wdata   <= wdata_n;
            mem_byteen  <= byteen_n;
            st_misalign <= misalign_n;
            st_buserr   <= buserr_n;
        end
    always_comb
        state_n = state == IDLE ? (go ? REQ : IDLE) : (mem_ready || last ? IDLE : REQ);
    // Request fields are captured only on acceptance and held for the whole REQ phase.
    always_comb begin
        st_stall   = go || (state == REQ && !mem_ready && !last);
        req_n      = st_stall;
        count_n    = go ? '0 : (state == REQ && st_stall) ? count + CW'(1) : count;
        addr_n     = go ? {addr[31:2], 2'b00} : mem_addr;
        wdata_n    = !go ? mem_wdata : sw ? wdata : sh ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
        byteen_n   = !go ? mem_byteen : sw ? 4'b1111 : sh ? (addr[1] ? 4'b1100 : 4'b0011)
                   : 4'b0001 << addr[1:0];
        misalign_n = store && !aligned;
        buserr_n   = state == REQ && !mem_ready && last;
    end
endmodule
